// File: rtl/step_key_gen.sv
// Step-button front end: synchronises and debounces the push-button, emits one
// step pulse per accepted press and captures the data switch on that pulse.
module step_key_gen #(
  parameter int unsigned DB_CYCLES = 2_000_000,
  parameter int unsigned HIST_W    = 8
) (
  input  logic              cp,
  input  logic              rd,
  input  logic              btn_raw,
  input  logic              x_raw,
  output logic              step,
  output logic              x_out,
  output logic [HIST_W-1:0] x_hist,
  output logic [7:0]        step_cnt
);
  localparam int unsigned CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, REL_WAIT} state_e;

  logic btn_meta_q, btn_s_q, x_meta_q, x_s_q;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic accept_d;
  logic step_q, x_out_q;
  logic [HIST_W-1:0] x_hist_q;
  logic [7:0] step_cnt_q;

  // State register, synchronisers and the registers updated on an accepted press.
  always_ff @(posedge cp) begin
    if (rd) begin
      btn_meta_q <= 1'b0;
      btn_s_q    <= 1'b0;
      x_meta_q   <= 1'b0;
      x_s_q      <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      step_q     <= 1'b0;
      x_out_q    <= 1'b0;
      x_hist_q   <= '0;
      step_cnt_q <= '0;
    end else begin
      btn_meta_q <= btn_raw;
      btn_s_q    <= btn_meta_q;
      x_meta_q   <= x_raw;
      x_s_q      <= x_meta_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      step_q     <= accept_d;
      if (accept_d) begin
        x_out_q    <= x_s_q;
        x_hist_q   <= {x_hist_q[HIST_W-2:0], x_s_q};
        step_cnt_q <= step_cnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_s_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = HELD;
          cnt_d    = '0;
          accept_d = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!btn_s_q) begin
          state_d = REL_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      REL_WAIT: begin
        if (btn_s_q) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    step     = step_q;
    x_out    = x_out_q;
    x_hist   = x_hist_q;
    step_cnt = step_cnt_q;
  end
endmodule
